fusion_sequencer: RTL and testbench

Parametrised main sequencer for the Kalman sensor-fusion datapath, generalising the fixed roll/pitch/yaw controller to NUM_GROUPS sensor groups with OUTS_PER_GROUP results each. It arbitrates round-robin among ready sensor groups and drives one group's load, filter and latch strobes. It then serialises that group's unmasked results to the output writer, one handshake per result. It sits between the sensor interface blocks, the per-group preprocessors and filters, and the output register/writer.

---
 rtl/fusion_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/fusion_sequencer.sv | 121 ++++++++++++
 tb/tb_fusion_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// fusion_pkg: sequencer state encoding and result-slot scan helper shared by fusion_sequencer
package fusion_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CALC, LATCH, OUTPUT} state_e;
  localparam int MAX_OUTS = 32;
  // Lowest unmasked slot in [start, n); returns n when none remain.
  function automatic logic [5:0] next_unmasked(input logic [MAX_OUTS-1:0] mask, input logic [5:0] start,
                                                input logic [5:0] n);
    next_unmasked = n;
    for (int i = MAX_OUTS - 1; i >= 0; i--)
      if (6'(i) >= start && 6'(i) < n && !mask[i]) next_unmasked = 6'(i);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after last, as one-hot plus index
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W:0] s;
  // Walk offsets from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    s = '0;
    for (int o = N; o >= 1; o--) begin
      s = (W + 1)'(last) + (W + 1)'(o);
      s = s >= (W + 1)'(N) ? s - (W + 1)'(N) : s;
      if (req[s[W-1:0]]) begin
        gnt = '0;
        gnt[s[W-1:0]] = 1'b1;
        idx = s[W-1:0];
      end
    end
  end
endmodule

// File: rtl/fusion_sequencer.sv
// fusion_sequencer: round-robin Kalman fusion sequencer with serialised result output
// Optional filter timeout enabled by defining FUSION_TIMEOUT_EN.
module fusion_sequencer
  import fusion_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int OUTS_PER_GROUP = 2,
  parameter int TIMEOUT_W = 16,
  localparam int SEL_W = $clog2(NUM_GROUPS * OUTS_PER_GROUP)
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 configured,
  input  logic [NUM_GROUPS-1:0]                sensor_ready,
  input  logic                                 kalman_done,
  input  logic                                 output_done,
  input  logic [NUM_GROUPS*OUTS_PER_GROUP-1:0] out_mask,
  input  logic [TIMEOUT_W-1:0]                 timeout_limit,
  output logic [NUM_GROUPS-1:0]                sensor_read,
  output logic [NUM_GROUPS-1:0]                load_group,
  output logic [NUM_GROUPS-1:0]                filter_enable,
  output logic [NUM_GROUPS-1:0]                latch_result,
  output logic                                 clear,
  output logic                                 write_enable,
  output logic [SEL_W-1:0]                     output_sel,
  output logic                                 busy,
  output logic                                 timeout_err
);
  localparam int GW = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1;
  localparam int IW = OUTS_PER_GROUP > 1 ? $clog2(OUTS_PER_GROUP) : 1;
  state_e                    state_q, state_d;
  logic [GW-1:0]             grp_q, grp_d, last_q, last_d, gnt_idx;
  logic [NUM_GROUPS-1:0]     gnt, grp_oh;
  logic [OUTS_PER_GROUP-1:0] mask_q, mask_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [5:0]                nxt;
`ifdef FUSION_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]      cnt_q, cnt_d;
  logic                      tmo_q, tmo_d, expire;
  assign expire = timeout_limit != '0 && cnt_q + TIMEOUT_W'(1) == timeout_limit;
  assign timeout_err = tmo_q;
`else
  logic                      unused_timeout_limit;
  assign unused_timeout_limit = ^timeout_limit;
  assign timeout_err = 1'b0;
`endif
  rr_arbiter #(.N(NUM_GROUPS)) u_arb (.req(sensor_ready), .last(last_q), .gnt(gnt), .idx(gnt_idx));
  assign nxt = next_unmasked(MAX_OUTS'(mask_q), state_q == LATCH ? 6'd0 : 6'(idx_q) + 6'd1,
                             6'(OUTS_PER_GROUP));
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    last_d  = last_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
`ifdef FUSION_TIMEOUT_EN
    tmo_d   = 1'b0;
    cnt_d   = cnt_q + TIMEOUT_W'(1);
`endif
    case (state_q)
      IDLE: if (configured && |gnt) begin
        state_d = LOAD;
        grp_d   = gnt_idx;
        last_d  = gnt_idx;
        mask_d  = OUTS_PER_GROUP'(out_mask >> (32'(gnt_idx) * OUTS_PER_GROUP));
      end
      LOAD: begin
        state_d = CALC;
`ifdef FUSION_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      CALC: begin
        state_d = kalman_done ? LATCH : CALC;
`ifdef FUSION_TIMEOUT_EN
        if (!kalman_done && expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
`endif
      end
      LATCH, OUTPUT: if (state_q == LATCH || output_done) begin
        state_d = nxt == 6'(OUTS_PER_GROUP) ? IDLE : OUTPUT;
        idx_d   = IW'(nxt);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      last_q  <= GW'(NUM_GROUPS - 1);
      mask_q  <= '0;
      idx_q   <= '0;
`ifdef FUSION_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
`ifdef FUSION_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end
  assign grp_oh        = NUM_GROUPS'(1) << grp_q;
  assign sensor_read   = state_q == LOAD ? grp_oh : '0;
  assign load_group    = state_q == LOAD ? grp_oh : '0;
  assign filter_enable = state_q == CALC ? grp_oh : '0;
  assign latch_result  = state_q == LATCH ? grp_oh : '0;
  assign clear         = state_q != CALC;
  assign write_enable  = state_q == OUTPUT;
  assign output_sel    = write_enable ? SEL_W'(32'(grp_q) * OUTS_PER_GROUP + 32'(idx_q)) : '0;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_fusion_sequencer.sv
// tb_fusion_sequencer: directed self-checking bench for fusion_sequencer (default 2x2 config)
module tb_fusion_sequencer;
  logic       clk = 1'b0;
  logic       n_rst, configured, kalman_done, output_done, clear, write_enable, busy, timeout_err;
  logic [1:0] sensor_ready, sensor_read, load_group, filter_enable, latch_result, output_sel;
  logic [3:0] out_mask;
  logic [15:0] timeout_limit;
  int n_chk = 0;
  int n_pass = 0;

  fusion_sequencer dut (
    .clk(clk), .n_rst(n_rst), .configured(configured), .sensor_ready(sensor_ready),
    .kalman_done(kalman_done), .output_done(output_done), .out_mask(out_mask),
    .timeout_limit(timeout_limit), .sensor_read(sensor_read), .load_group(load_group),
    .filter_enable(filter_enable), .latch_result(latch_result), .clear(clear),
    .write_enable(write_enable), .output_sel(output_sel), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string p);
    check({p, "_read"}, 32'(sensor_read), 0);
    check({p, "_load"}, 32'(load_group), 0);
    check({p, "_fe"}, 32'(filter_enable), 0);
    check({p, "_latch"}, 32'(latch_result), 0);
    check({p, "_clear"}, 32'(clear), 1);
    check({p, "_we"}, 32'(write_enable), 0);
    check({p, "_sel"}, 32'(output_sel), 0);
    check({p, "_busy"}, 32'(busy), 0);
    check({p, "_tmo"}, 32'(timeout_err), 0);
  endtask

  task automatic reset_dut();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
  endtask

  task automatic wait_load();
    int k = 0;
    while (load_group == 2'b00 && k < 8) begin
      step();
      k++;
    end
    check("load_seen", 32'(k < 8), 1);
  endtask

  // One full transaction: grant -> CALC for cw cycles -> latch -> drain writes.
  task automatic txn(input logic [1:0] rdy, input logic [3:0] msk, input int g, input int cw,
                     input int nw, input int s0, input int s1);
    int k = 0;
    int w = 0;
    int sels[2] = '{0, 0};
    sensor_ready = rdy;
    out_mask = msk;
    wait_load();
    check("load_grp", 32'(load_group), 32'(1 << g));
    check("read_grp", 32'(sensor_read), 32'(1 << g));
    out_mask = ~msk;
    step();
    check("calc_fe", 32'(filter_enable), 32'(1 << g));
    check("calc_clear", 32'(clear), 0);
    repeat (cw - 1) step();
    kalman_done = 1'b1;
    step();
    kalman_done = 1'b0;
    check("latch_grp", 32'(latch_result), 32'(1 << g));
    while (busy && k < 20) begin
      output_done = write_enable;
      if (write_enable) begin
        if (w < 2) sels[w] = 32'(output_sel);
        w++;
      end
      step();
      k++;
    end
    output_done = 1'b0;
    sensor_ready = 2'b00;
    check("txn_done", 32'(k < 20), 1);
    check("n_writes", 32'(w), 32'(nw));
    if (nw > 0) check("sel0", 32'(sels[0]), 32'(s0));
    if (nw > 1) check("sel1", 32'(sels[1]), 32'(s1));
  endtask

  initial begin
    n_rst = 1'b0;
    configured = 1'b0;
    sensor_ready = 2'b00;
    kalman_done = 1'b0;
    output_done = 1'b0;
    out_mask = 4'b0000;
    timeout_limit = 16'd0;
    repeat (2) step();
    check_reset("rst");
    n_rst = 1'b1;
    configured = 1'b1;
    txn(2'b01, 4'b0000, 0, 5, 2, 0, 1);
    check("idle_after", 32'(busy), 0);

    reset_dut();
    txn(2'b11, 4'b0000, 0, 2, 2, 0, 1);
    txn(2'b11, 4'b0000, 1, 2, 2, 2, 3);
    txn(2'b11, 4'b0000, 0, 2, 2, 0, 1);

    txn(2'b10, 4'b0100, 1, 2, 1, 3, 0);
    txn(2'b10, 4'b1100, 1, 2, 0, 0, 0);

    sensor_ready = 2'b01;
    out_mask = 4'b0000;
    wait_load();
    step();
    kalman_done = 1'b1;
    step();
    kalman_done = 1'b0;
    step();
    sensor_ready = 2'b00;
    repeat (10) begin
      check("stall_we", 32'(write_enable), 1);
      check("stall_sel", 32'(output_sel), 0);
      step();
    end
    output_done = 1'b1;
    step();
    output_done = 1'b0;
    check("adv_we", 32'(write_enable), 1);
    check("adv_sel", 32'(output_sel), 1);
    step();
    check("hold_sel", 32'(output_sel), 1);
    output_done = 1'b1;
    step();
    output_done = 1'b0;
    check("stall_idle", 32'(busy), 0);

`ifdef FUSION_TIMEOUT_EN
    timeout_limit = 16'd8;
    sensor_ready = 2'b01;
    wait_load();
    sensor_ready = 2'b00;
    step();
    repeat (7) begin
      check("tmo_early", 32'(timeout_err), 0);
      step();
    end
    check("calc8_fe", 32'(filter_enable), 1);
    step();
    check("tmo_pulse", 32'(timeout_err), 1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_nolatch", 32'(latch_result), 0);
    step();
    check("tmo_once", 32'(timeout_err), 0);
    sensor_ready = 2'b01;
    wait_load();
    sensor_ready = 2'b00;
    step();
    repeat (7) step();
    kalman_done = 1'b1;
    step();
    kalman_done = 1'b0;
    check("race_latch", 32'(latch_result), 1);
    check("race_tmo", 32'(timeout_err), 0);
    timeout_limit = 16'd0;
`else
    sensor_ready = 2'b01;
    wait_load();
    sensor_ready = 2'b00;
    repeat (20) step();
    check("wait_fe", 32'(filter_enable), 1);
    check("wait_tmo", 32'(timeout_err), 0);
    kalman_done = 1'b1;
    step();
    kalman_done = 1'b0;
    check("wait_latch", 32'(latch_result), 1);
`endif
    output_done = 1'b1;
    for (int k = 0; k < 10 && busy; k++) step();
    output_done = 1'b0;
    check("drain_idle", 32'(busy), 0);

    reset_dut();
    sensor_ready = 2'b01;
    wait_load();
    sensor_ready = 2'b00;
    step();
    kalman_done = 1'b1;
    step();
    kalman_done = 1'b0;
    step();
    check("mid_we", 32'(write_enable), 1);
    n_rst = 1'b0;
    sensor_ready = 2'b11;
    step();
    check_reset("mid");
    n_rst = 1'b1;
    step();
    check("post_rst_grant", 32'(load_group), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
